truth_table_capture: RTL
========================

# truth_table_capture

- Sequential truth-table sweeper and checker for N-input combinational boolean functions; it is the consuming end of the truth-table flow.
- It drives every input minterm in ascending order into a function-under-test and samples the function's 1-bit output after a settle delay.
- It assembles the output column as a minterm mask and compares it against an expected mask.
- It sits beside the fxy-style expression modules, so a truth table is captured and verified in hardware instead of printed.

## Interface
- N_VARS, default 3: number of function inputs; mask width is 2^N_VARS.
- SETTLE, default 1: clock cycles inputs are held stable before the output is sampled; legal range 0 to 15.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sweep; honoured only in IDLE or DONE.
- expected, input, 2^N_VARS: expected output column; bit m is the output for minterm m; sampled on the accepted start.
- vars, output, N_VARS: drives the function inputs; bit N_VARS-1 is x (MSB), bit 0 is the last variable (z for N=3).
- s_in, input, 1: function output under test.
- busy, output, 1: high from the accepted start until the last sample is taken.
- done, output, 1: one-cycle pulse when the result is valid.
- mask, output, 2^N_VARS: captured output column.
- pass, output, 1: high when mask equals the captured expected value.
- mismatch, output, 2^N_VARS: mask XOR captured expected.
- first_fail, output, N_VARS: lowest minterm index with a mismatch; 0 if none.

## Operation
- Reset values: state IDLE; vars=0, busy=0, done=0, mask=0, pass=0, mismatch=0, first_fail=0.
- IDLE:
  - On start=1: latch expected into exp_q, clear mask, set minterm m=0, drive vars=0, go to SETTLE_ST.
- SETTLE_ST:
  - Hold vars=m.
  - Count SETTLE cycles, then go to SAMPLE.
  - If SETTLE=0, SAMPLE follows directly.
- SAMPLE:
  - Write mask[m]=s_in.
  - If m = 2^N_VARS-1: go to DONE.
  - Otherwise: m=m+1, vars=m+1, go to SETTLE_ST.
- DONE:
  - Pulse done for one cycle; mismatch, pass and first_fail become valid in that same cycle and hold until the next accepted start.
  - Then idle in DONE.
  - start in DONE begins a new sweep, identical to IDLE.
- start while busy is ignored. The sweep is not restarted and exp_q is not re-latched.
- Changes on the expected input during a sweep have no effect.
- The minterm counter is N_VARS+1 bits wide internally; end of sweep is detected by compare, so there is no wrap to 0.
- first_fail is the priority-encoded lowest set bit of mismatch.
- Reset asserted mid-sweep aborts immediately to the reset values; a partial mask is discarded.

## Timing
- Each minterm occupies SETTLE+1 cycles (SETTLE hold cycles plus one SAMPLE cycle).
- vars changes on the clock edge that enters SETTLE_ST for the new minterm.
- s_in is sampled on the edge that ends SAMPLE.
- Latency from the accepted start edge to the done pulse is 2^N_VARS*(SETTLE+1)+1 cycles. For N=3, SETTLE=1 this is 17 cycles.
- busy deasserts on the same edge that done asserts.
- The earliest restart is start asserted in the done cycle, accepted on the following edge.

## Structure
- Shared package tt_pkg:
  - tt_state_t enum: IDLE, SETTLE_ST, SAMPLE, DONE.
  - Localparam helper for mask width (1<<N_VARS).
  - Function lowest_set_index used for first_fail.
- One sub-module, tt_settle_timer: a loadable down-counter with a zero flag, 4 bits wide, parameterised by SETTLE.
- The top level holds the FSM, minterm counter, mask shift/write logic and compare logic.

## Test plan
- Function fxy4 s=~(x&~y)&z, expected=8'h8A, SETTLE=1:
  - vars sequence 0..7, each held 2 cycles.
  - mask=8'h8A, pass=1, mismatch=0.
  - done exactly 17 cycles after start.
- Same DUT, expected=8'hAA:
  - mask=8'h8A, pass=0, mismatch=8'h20, first_fail=5.
- Function s=~y, SETTLE=0:
  - mask=8'h33, done 9 cycles after start.
  - A second start pulsed in the done cycle completes a second identical sweep.
- Reset mid-sweep:
  - Drop rst_n while m=4; all outputs immediately at reset values.
  - After release, a new start produces a full, correct sweep.
- start pulsed mid-sweep with a different expected value:
  - Ignored; result is compared against the originally latched expected, and done timing is unchanged.
- N_VARS=2, function s=x&~y:
  - mask=4'b0100, first_fail=0, pass=1 with expected=4'h4.

Source files
------------

// File: rtl/tt_pkg.sv
// ============================================================================
// tt_pkg : shared types and helpers for the truth-table capture block
// Rev 1.0
// ============================================================================
`default_nettype none

package tt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE    = 2'd2,
    DONE      = 2'd3
  } tt_state_t;

  localparam int TT_MAX_VARS = 8;
  localparam int TT_MAX_MW   = 1 << TT_MAX_VARS;

  function automatic int tt_mask_width(input int n);
    return 1 << n;
  endfunction

  // Scan from the top so the last hit wins, leaving the lowest set bit.
  function automatic int lowest_set_index(input logic [TT_MAX_MW-1:0] v);
    int idx;
    idx = 0;
    for (int i = TT_MAX_MW - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_settle_timer.sv
// ============================================================================
// tt_settle_timer : loadable 4-bit down-counter with zero flag
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  // Zero is reached after SETTLE cycles of holding, so load one less.
  localparam logic [3:0] C_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= C_LOAD;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/truth_table_capture.sv
// ============================================================================
// truth_table_capture : sweeps all minterms, captures and checks the output
// Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_capture
  import tt_pkg::*;
#(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [(1<<N_VARS)-1:0]   i_expected,
  output logic [N_VARS-1:0]        o_vars,
  input  logic                     i_s_in,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [(1<<N_VARS)-1:0]   o_mask,
  output logic                     o_pass,
  output logic [(1<<N_VARS)-1:0]   o_mismatch,
  output logic [N_VARS-1:0]        o_first_fail
);

  localparam int MW = tt_mask_width(N_VARS);
  localparam tt_state_t C_HOLD_ST = (SETTLE == 0) ? SAMPLE : SETTLE_ST;

  tt_state_t         r_state;
  logic [N_VARS:0]   r_m;
  logic [N_VARS-1:0] r_vars;
  logic [MW-1:0]     r_exp;
  logic [MW-1:0]     r_mask;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [MW-1:0]     r_mis;
  logic [N_VARS-1:0] r_ff;

  logic                 w_last;
  logic                 w_accept;
  logic                 w_tmr_load;
  logic                 w_tmr_dec;
  logic                 w_tmr_zero;
  logic [MW-1:0]        w_mis;
  logic [TT_MAX_MW-1:0] w_mis_ext;
  logic [N_VARS-1:0]    w_first;

  assign w_last     = (r_m == (N_VARS+1)'(MW - 1));
  assign w_accept   = i_start && !r_busy && ((r_state == IDLE) || (r_state == DONE));
  assign w_tmr_load = w_accept || ((r_state == SAMPLE) && !w_last);
  assign w_tmr_dec  = (r_state == SETTLE_ST);
  assign w_mis      = r_mask ^ r_exp;

  always_comb begin
    w_mis_ext         = '0;
    w_mis_ext[MW-1:0] = w_mis;
  end

  assign w_first = N_VARS'(lowest_set_index(w_mis_ext));

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_dec  (w_tmr_dec),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_vars  <= '0;
      r_exp   <= '0;
      r_mask  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mis   <= '0;
      r_ff    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_exp   <= i_expected;
            r_mask  <= '0;
            r_m     <= '0;
            r_vars  <= '0;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_mis   <= '0;
            r_ff    <= '0;
            r_state <= C_HOLD_ST;
          end else if ((r_state == DONE) && r_busy) begin
            // Mask is complete: publish the compare results with the done pulse.
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_mis  <= w_mis;
            r_pass <= (w_mis == '0);
            r_ff   <= w_first;
          end
        end
        SETTLE_ST: begin
          if (w_tmr_zero) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_mask[r_m[N_VARS-1:0]] <= i_s_in;
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_m     <= r_m + (N_VARS+1)'(1);
            r_vars  <= r_vars + N_VARS'(1);
            r_state <= C_HOLD_ST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_vars       = r_vars;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_mask       = r_mask;
  assign o_pass       = r_pass;
  assign o_mismatch   = r_mis;
  assign o_first_fail = r_ff;

endmodule

`default_nettype wire
